// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit mini CPU.
// Owns the PC, fetches opcode/immediate bytes and drives register file and ALU controls.
module cpu_control_fsm #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ready,
  input  logic [7:0] imem_data,
  output logic [1:0] rf_rs1,
  output logic [1:0] rf_rs2,
  output logic [1:0] rf_rd,
  output logic       rf_write_en,
  output logic [7:0] rf_write_data,
  input  logic [7:0] rf_read_data1,
  input  logic [7:0] rf_read_data2,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       halted,
  output logic       illegal_op
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_IMM    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0] state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] ir_reg, ir_next;
  logic [7:0] imm_reg, imm_next;
  logic [3:0] opcode;

  assign opcode = ir_reg[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= 8'h00;
      imm_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      imm_reg   <= imm_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    imm_next   = imm_reg;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          ir_next    = imem_data;
          pc_next    = pc_reg + 8'd1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_LDI || opcode == OP_JMP || opcode == OP_BEQZ)
          state_next = S_IMM;
        else if (opcode != OP_NOP && opcode <= OP_MOV)
          state_next = S_EXEC;
        else if (opcode == OP_HALT)
          state_next = S_HALT;
        else
          state_next = S_FETCH;  // NOP and illegal opcodes
      end
      S_IMM: begin
        if (imem_ready) begin
          imm_next   = imem_data;
          pc_next    = pc_reg + 8'd1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode == OP_JMP || (opcode == OP_BEQZ && rf_read_data1 == 8'h00))
          pc_next = imm_reg;
        state_next = S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so an async reset clears them at once.
  always_comb begin
    imem_req      = (state_reg == S_FETCH) || (state_reg == S_IMM);
    imem_addr     = imem_req ? pc_reg : 8'h00;
    rf_rs1        = ir_reg[3:2];
    rf_rs2        = ir_reg[1:0];
    rf_rd         = ir_reg[3:2];
    rf_write_en   = 1'b0;
    rf_write_data = 8'h00;
    alu_op        = 3'd0;
    halted        = (state_reg == S_HALT);
    illegal_op    = (state_reg == S_DECODE) && (opcode >= 4'hA) && (opcode <= 4'hE);
    if (state_reg == S_EXEC) begin
      if (opcode != OP_NOP && opcode <= OP_XOR) begin
        alu_op        = opcode[2:0] - 3'd1;
        rf_write_en   = 1'b1;
        rf_write_data = alu_result;
      end else if (opcode == OP_MOV) begin
        rf_write_en   = 1'b1;
        rf_write_data = rf_read_data2;
      end else if (opcode == OP_LDI) begin
        rf_write_en   = 1'b1;
        rf_write_data = imm_reg;
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: memory, register file and ALU models around the DUT.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ready = 1'b0;
  logic [7:0] imem_data;
  logic [1:0] rf_rs1, rf_rs2, rf_rd;
  logic       rf_write_en;
  logic [7:0] rf_write_data;
  logic [7:0] rf_read_data1, rf_read_data2;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       halted, illegal_op;

  logic [7:0] mem [256];
  logic [7:0] rf  [4];
  logic [7:0] exp_fetch [$];
  logic [9:0] exp_wr [$];

  int total = 0;
  int bad   = 0;
  int cyc, halt_cyc, wr_cnt, ill_cnt, stall_left;
  logic [7:0] stall_addr;

  cpu_control_fsm #(.RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .alu_op(alu_op), .alu_result(alu_result),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign imem_data     = mem[imem_addr];
  assign rf_read_data1 = rf[rf_rs1];
  assign rf_read_data2 = rf[rf_rs2];

  always_comb begin
    case (alu_op)
      3'd0:    alu_result = rf_read_data1 + rf_read_data2;
      3'd1:    alu_result = rf_read_data1 - rf_read_data2;
      3'd2:    alu_result = rf_read_data1 & rf_read_data2;
      3'd3:    alu_result = rf_read_data1 | rf_read_data2;
      3'd4:    alu_result = rf_read_data1 ^ rf_read_data2;
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) if (rf_write_en) rf[rf_rd] <= rf_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: decides imem_ready for the coming edge and pops the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      cyc = 0;
      imem_ready = 1'b0;
    end else begin
      cyc++;
      if (imem_req) begin
        if (stall_left > 0 && imem_addr == stall_addr) begin
          imem_ready = 1'b0;
          stall_left--;
          check("stall_addr", imem_addr, stall_addr);
          check("stall_no_write", rf_write_en, 0);
        end else begin
          imem_ready = 1'b1;
          if (exp_fetch.size() == 0) check("fetch_unexpected", exp_fetch.size(), 1);
          else begin
            $display("fetch addr=%02h data=%02h", imem_addr, imem_data);
            check("fetch_addr", imem_addr, exp_fetch.pop_front());
          end
        end
      end else begin
        imem_ready = 1'($urandom_range(0, 1));  // must be ignored without a request
      end
      if (rf_write_en) begin
        wr_cnt++;
        $display("write rd=%0d data=%02h", rf_rd, rf_write_data);
        if (exp_wr.size() == 0) check("write_unexpected", exp_wr.size(), 1);
        else check("write_rd_data", {rf_rd, rf_write_data}, exp_wr.pop_front());
      end
      if (illegal_op) ill_cnt++;
      if (halted && halt_cyc == 0) halt_cyc = cyc;
    end
  end

  task automatic prep();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    exp_fetch.delete();
    exp_wr.delete();
    wr_cnt = 0; ill_cnt = 0; stall_left = 0; halt_cyc = 0; stall_addr = 8'h00;
  endtask

  task automatic go();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int exp_cyc);
    int n = 0;
    while (!halted && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_halt_reached"}, halted, 1);
    @(negedge clk); #1;
    check({tag, "_halt_cycle"}, halt_cyc, exp_cyc);
    check({tag, "_fetch_left"}, exp_fetch.size(), 0);
    check({tag, "_write_left"}, exp_wr.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_we"}, rf_write_en, 0);
    check({tag, "_wdata"}, rf_write_data, 0);
    check({tag, "_aluop"}, alu_op, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_illegal"}, illegal_op, 0);
    check({tag, "_regaddr"}, {rf_rs1, rf_rs2, rf_rd}, 0);
  endtask

  task automatic load_basic();
    mem[0] = 8'h73; mem[1] = 8'h05; mem[2] = 8'h74; mem[3] = 8'h03;
    mem[4] = 8'h1D; mem[5] = 8'hF0;
    for (int a = 0; a < 6; a++) exp_fetch.push_back(8'(a));
    exp_wr.push_back({2'd0, 8'h05});
    exp_wr.push_back({2'd1, 8'h03});
    exp_wr.push_back({2'd3, 8'h03});
  endtask

  initial begin
    int hold_bad;
    logic [7:0] prog [10];

    // reset state
    prep();
    #2 chk_zero("reset");

    // illegal opcode followed by HALT
    prep();
    mem[0] = 8'hB4; mem[1] = 8'hF0;
    exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
    go();
    wait_halt("illegal", 6);
    check("illegal_pulses", ill_cnt, 1);
    check("illegal_writes", wr_cnt, 0);

    // HALT holds for 20 cycles, then reset clears it
    hold_bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (imem_req !== 1'b0 || halted !== 1'b1) hold_bad++;
    end
    check("halt_hold", hold_bad, 0);
    reset = 1'b1; #1;
    check("halt_cleared", halted, 0);

    // basic LDI/LDI/ADD program, zero-wait memory
    prep();
    load_basic();
    go();
    wait_halt("basic", 15);
    check("basic_write_count", wr_cnt, 3);

    // same program with 4 stall cycles on the fetch at PC=2
    prep();
    load_basic();
    stall_addr = 8'h02; stall_left = 4;
    go();
    wait_halt("stall", 19);
    check("stall_write_count", wr_cnt, 3);

    // every ALU op plus MOV
    prep();
    prog = '{8'h70, 8'h09, 8'h74, 8'h03, 8'h21, 8'h35, 8'h48, 8'h5C, 8'h61, 8'hF0};
    for (int a = 0; a < 10; a++) begin
      mem[a] = prog[a];
      exp_fetch.push_back(8'(a));
    end
    exp_wr.push_back({2'd0, 8'h09}); exp_wr.push_back({2'd1, 8'h03});
    exp_wr.push_back({2'd0, 8'h06}); exp_wr.push_back({2'd1, 8'h03});
    exp_wr.push_back({2'd2, 8'h06}); exp_wr.push_back({2'd3, 8'h06});
    exp_wr.push_back({2'd0, 8'h03});
    go();
    wait_halt("alu", 27);

    // BEQZ taken/not taken, JMP to 0xFF wrapping to 0x00
    prep();
    rf[1] = 8'h07;
    mem[8'h00] = 8'h90; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h94; mem[8'h11] = 8'h20;
    mem[8'h12] = 8'h70; mem[8'h13] = 8'h01;
    mem[8'h14] = 8'h80; mem[8'h15] = 8'hFF;
    mem[8'hFF] = 8'h00;
    mem[8'h02] = 8'hF0;
    prog = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hFF, 8'h00};
    for (int a = 0; a < 10; a++) exp_fetch.push_back(prog[a]);
    exp_fetch.push_back(8'h01); exp_fetch.push_back(8'h02);
    exp_wr.push_back({2'd0, 8'h01});
    go();
    wait_halt("branch", 26);

    // reset during EXEC of an ADD
    prep();
    mem[0] = 8'h1D; mem[1] = 8'hF0;
    rf[1] = 8'h04; rf[3] = 8'h06;
    exp_fetch.push_back(8'h00);
    go();
    repeat (3) @(posedge clk);
    #1 check("abort_exec_in_exec", rf_write_en, 1);
    reset = 1'b1;
    #1 chk_zero("abort_exec");
    @(posedge clk); #1;
    check("abort_exec_no_write", rf[3], 8'h06);
    check("abort_exec_fetch_left", exp_fetch.size(), 0);
    exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
    exp_wr.push_back({2'd3, 8'h0A});
    go();
    wait_halt("restart_exec", 7);

    // reset while stalled in IMM
    prep();
    mem[0] = 8'h73; mem[1] = 8'h05; mem[2] = 8'hF0;
    stall_addr = 8'h01; stall_left = 10;
    exp_fetch.push_back(8'h00);
    go();
    repeat (5) @(posedge clk);
    #1 check("abort_imm_stalled", {imem_req, imem_addr}, {1'b1, 8'h01});
    reset = 1'b1;
    #1 chk_zero("abort_imm");
    prep();
    mem[0] = 8'h73; mem[1] = 8'h05; mem[2] = 8'hF0;
    for (int a = 0; a < 3; a++) exp_fetch.push_back(8'(a));
    exp_wr.push_back({2'd0, 8'h05});
    go();
    wait_halt("restart_imm", 8);
    check("restart_imm_r0", rf[0], 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
